inst_prefetch_queue: RTL and testbench

INST_PREFETCH_QUEUE -- requirements
Module: inst_prefetch_queue

---
 rtl/inst_prefetch_queue.sv | 88 ++++++++
 tb/tb_inst_prefetch_queue.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/inst_prefetch_queue.sv
// inst_prefetch_queue: credit-limited instruction prefetcher feeding a show-ahead FIFO
module inst_prefetch_queue #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH = 4,
  parameter int MAX_OUT = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect_i,
  input  logic [ADDR_W-1:0]          redirect_pc_i,
  output logic                       rom_ce_o,
  output logic [ADDR_W-1:0]          rom_addr_o,
  input  logic [INST_W-1:0]          rom_data_i,
  input  logic                       rom_valid_i,
  output logic                       inst_valid_o,
  output logic [INST_W-1:0]          inst_o,
  output logic [ADDR_W-1:0]          inst_pc_o,
  input  logic                       inst_ready_i,
  output logic [$clog2(DEPTH):0]     level_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int OW = $clog2(MAX_OUT + 1);
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, push_pc_q, push_pc_d, redir_pc;
  logic [OW-1:0]     out_q, out_d, drop_q, drop_d;
  logic [LW-1:0]     level_q, level_d;
  logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d;
  logic [INST_W-1:0] inst_mem_q [DEPTH];
  logic [INST_W-1:0] inst_mem_d [DEPTH];
  logic [ADDR_W-1:0] pc_mem_q [DEPTH];
  logic [ADDR_W-1:0] pc_mem_d [DEPTH];
  logic              resp, push, pop;
  // a request is only issued when the queue has a guaranteed slot for its response
  assign rom_ce_o     = rst && !redirect_i && (32'(out_q) < MAX_OUT) && (32'(out_q) + 32'(level_q) < DEPTH);
  assign rom_addr_o   = fetch_pc_q;
  assign inst_valid_o = (level_q != '0) && !redirect_i;
  assign inst_o       = inst_mem_q[rd_q];
  assign inst_pc_o    = pc_mem_q[rd_q];
  assign level_o      = level_q;
  assign redir_pc     = {redirect_pc_i[ADDR_W-1:2], 2'b00};
  // next-state: counters, pointers, redirect flush and stale-response dropping
  always_comb begin
    resp       = rom_valid_i && (out_q != '0);
    push       = resp && (drop_q == '0) && !redirect_i;
    pop        = inst_valid_o && inst_ready_i;
    inst_mem_d = inst_mem_q;
    pc_mem_d   = pc_mem_q;
    fetch_pc_d = redirect_i ? redir_pc : rom_ce_o ? fetch_pc_q + ADDR_W'(4) : fetch_pc_q;
    push_pc_d  = redirect_i ? redir_pc : push ? push_pc_q + ADDR_W'(4) : push_pc_q;
    out_d      = out_q + OW'(rom_ce_o) - OW'(resp);
    drop_d     = redirect_i ? out_q - OW'(resp) : (resp && drop_q != '0) ? drop_q - OW'(1) : drop_q;
    level_d    = redirect_i ? '0 : level_q + LW'(push) - LW'(pop);
    wr_d       = redirect_i ? '0 : wr_q + PW'(push);
    rd_d       = redirect_i ? '0 : rd_q + PW'(pop);
    if (push) begin
      inst_mem_d[wr_q] = rom_data_i;
      pc_mem_d[wr_q]   = push_pc_q;
    end
  end
  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      push_pc_q  <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
      level_q    <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      push_pc_q  <= push_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      level_q    <= level_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      inst_mem_q <= inst_mem_d;
      pc_mem_q   <= pc_mem_d;
    end
  end
endmodule

// File: tb/tb_inst_prefetch_queue.sv
// tb_inst_prefetch_queue: scoreboard bench with an in-order variable-latency ROM model
module tb_inst_prefetch_queue;
  typedef struct {logic [31:0] a; int due; bit stale;} req_t;
  typedef struct {logic [31:0] pc; logic [31:0] inst;} ent_t;
  logic        clk = 0, rst = 0, redirect_i = 0, rom_valid_i = 0, inst_ready_i = 0;
  logic [31:0] redirect_pc_i = 0, rom_data_i = 0, rom_addr_o, inst_o, inst_pc_o;
  logic        rom_ce_o, inst_valid_o;
  logic [2:0]  level_o;
  logic        w_ce, w_valid = 0, w_iv;
  logic [31:0] w_addr, w_data = 0, w_inst, w_pc;
  logic [2:0]  w_level;
  logic [31:0] w_pcs [3];
  int          wn = 0;
  int          n_chk = 0, n_err = 0, cyc = 0, lat = 1;
  bit          spur = 0;
  logic [31:0] efetch = 0;
  req_t        pend [$];
  ent_t        exp_q [$];

  inst_prefetch_queue dut (
    .clk(clk), .rst(rst), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .rom_ce_o(rom_ce_o), .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i), .rom_valid_i(rom_valid_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_pc_o(inst_pc_o), .inst_ready_i(inst_ready_i),
    .level_o(level_o)
  );

  inst_prefetch_queue #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst(rst), .redirect_i(1'b0), .redirect_pc_i(32'h0),
    .rom_ce_o(w_ce), .rom_addr_o(w_addr), .rom_data_i(w_data), .rom_valid_i(w_valid),
    .inst_valid_o(w_iv), .inst_o(w_inst), .inst_pc_o(w_pc), .inst_ready_i(1'b1),
    .level_o(w_level)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
  endfunction

  always @(posedge clk) begin
    w_valid <= w_ce;
    w_data  <= rom_word(w_addr);
  end

  always @(negedge clk)
    if (rst && w_iv === 1'b1 && wn < 3) begin
      w_pcs[wn] = w_pc;
      wn++;
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%h want=%h cyc=%0d", tag, got, want, cyc);
    end
  endtask

  task automatic step();
    logic del, ece, ev;
    req_t r;
    del = rst && pend.size() > 0 && pend[0].due <= cyc;
    rom_valid_i = del || spur;
    rom_data_i = del ? rom_word(pend[0].a) : 32'hDEAD_BEEF;
    #1;
    ece = rst && !redirect_i && pend.size() < 2 && pend.size() + exp_q.size() < 4;
    chk("ce", 32'(rom_ce_o), 32'(ece));
    if (ece) chk("addr", rom_addr_o, efetch);
    chk("level", 32'(level_o), exp_q.size());
    ev = exp_q.size() > 0 && !redirect_i;
    chk("valid", 32'(inst_valid_o), 32'(ev));
    if (ev) begin
      chk("pc", inst_pc_o, exp_q[0].pc);
      chk("inst", inst_o, exp_q[0].inst);
    end
    if (!rst) begin
      pend.delete();
      exp_q.delete();
      efetch = 0;
    end else begin
      if (ev && inst_ready_i) void'(exp_q.pop_front());
      if (redirect_i) begin
        exp_q.delete();
        foreach (pend[i]) pend[i].stale = 1;
        efetch = {redirect_pc_i[31:2], 2'b00};
      end
      if (del) begin
        r = pend.pop_front();
        if (!r.stale) exp_q.push_back('{r.a, rom_word(r.a)});
      end
      if (ece) begin
        pend.push_back('{efetch, cyc + lat, 1'b0});
        efetch += 4;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_out2();
    for (int i = 0; i < 20 && pend.size() != 2; i++) step();
    chk("out2", pend.size(), 2);
  endtask

  initial begin
    @(negedge clk);
    run(3);
    chk("rst_inst", inst_o, 0);
    chk("rst_pc", inst_pc_o, 0);
    rst = 1; inst_ready_i = 1; lat = 1;
    run(20);
    redirect_i = 1; redirect_pc_i = 32'h40;
    step();
    redirect_i = 0;
    chk("r36_lvl", 32'(level_o), 0);
    run(10);
    rst = 0; step();
    rst = 1; inst_ready_i = 0; lat = 2;
    run(10);
    chk("bp_lvl", 32'(level_o), 4);
    chk("bp_ce", 32'(rom_ce_o), 0);
    chk("bp_head", inst_pc_o, 0);
    spur = 1; step(); spur = 0;
    chk("bp_spur_lvl", 32'(level_o), 4);
    inst_ready_i = 1;
    run(10);
    lat = 3;
    wait_out2();
    redirect_i = 1; redirect_pc_i = 32'h103;
    step();
    redirect_i = 0;
    chk("r35_addr", rom_addr_o, 32'h100);
    run(15);
    wait_out2();
    redirect_i = 1; redirect_pc_i = 32'h80;
    step();
    redirect_i = 0;
    step();
    redirect_i = 1; redirect_pc_i = 32'h200;
    step();
    redirect_i = 0;
    run(20);
    wait_out2();
    rst = 0; step();
    rst = 1; spur = 1; step(); spur = 0;
    run(20);
    chk("wrap_n", wn, 3);
    chk("wrap0", w_pcs[0], 32'hFFFF_FFF8);
    chk("wrap1", w_pcs[1], 32'hFFFF_FFFC);
    chk("wrap2", w_pcs[2], 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
